// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin arbiter sharing one combinational W-bit ALU
//   clk, reset            : single clock, synchronous active-high reset
//   reqN_valid/ready      : request handshake for port N (N = 0, 1)
//   reqN_op/a/b/cin/lock  : opcode, operands, carry in, hold-grant request
//   rspN_valid            : one-cycle pulse, response for port N
//   rspN_result/cout      : result and carry out, held between pulses
//   Macro ALU_ARB_LOCK_EN : enables grant locking via reqN_lock
module alu_arbiter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [2:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_cin,
  input  logic         req0_lock,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [2:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_cin,
  input  logic         req1_lock,
  output logic         rsp0_valid,
  output logic [W-1:0] rsp0_result,
  output logic         rsp0_cout,
  output logic         rsp1_valid,
  output logic [W-1:0] rsp1_result,
  output logic         rsp1_cout
);
  logic         g0, g1;
  logic         ptr_q, ptr_d;
  logic         s1_v_q, s1_v_d, s1_id_q, s1_id_d, s1_cin_q, s1_cin_d;
  logic [2:0]   s1_op_q, s1_op_d;
  logic [W-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [W:0]   alu, a_e, b_e;
  logic         rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
  logic [W:0]   rsp0_res_q, rsp0_res_d, rsp1_res_q, rsp1_res_d;
`ifdef ALU_ARB_LOCK_EN
  logic         own_v_q, own_v_d, own_id_q, own_id_d;
`else
  logic         lock_unused;
  assign lock_unused = req0_lock ^ req1_lock;
`endif
  always_comb begin
`ifdef ALU_ARB_LOCK_EN
    // an owner excludes the other port even while the owner is idle
    g0 = !reset & req0_valid & (own_v_q ? !own_id_q : (!req1_valid | !ptr_q));
    g1 = !reset & req1_valid & (own_v_q ?  own_id_q : (!req0_valid |  ptr_q));
    own_v_d  = g0 ? req0_lock : g1 ? req1_lock : own_v_q;
    own_id_d = g1 ? 1'b1 : g0 ? 1'b0 : own_id_q;
`else
    g0 = !reset & req0_valid & (!req1_valid | !ptr_q);
    g1 = !reset & req1_valid & (!req0_valid |  ptr_q);
`endif
    ptr_d    = g0 ? 1'b1 : g1 ? 1'b0 : ptr_q;
    s1_v_d   = g0 | g1;
    s1_id_d  = g1 ? 1'b1 : g0 ? 1'b0 : s1_id_q;
    s1_op_d  = g1 ? req1_op  : g0 ? req0_op  : s1_op_q;
    s1_a_d   = g1 ? req1_a   : g0 ? req0_a   : s1_a_q;
    s1_b_d   = g1 ? req1_b   : g0 ? req0_b   : s1_b_q;
    s1_cin_d = g1 ? req1_cin : g0 ? req0_cin : s1_cin_q;
    a_e = {1'b0, s1_a_q};
    b_e = {1'b0, s1_b_q};
    // W+1-bit arithmetic so the carry (or borrow) lands in the top bit
    alu = s1_op_q == 3'd0 ? a_e :
          s1_op_q == 3'd1 ? {1'b0, ~s1_a_q} :
          s1_op_q == 3'd2 ? a_e + b_e + (W+1)'(s1_cin_q) :
          s1_op_q == 3'd3 ? a_e - b_e + (W+1)'(s1_cin_q) :
          s1_op_q == 3'd4 ? {1'b0, s1_a_q | s1_b_q} :
          s1_op_q == 3'd5 ? {1'b0, s1_a_q & s1_b_q} : '0;
    rsp0_valid_d = s1_v_q & !s1_id_q;
    rsp1_valid_d = s1_v_q &  s1_id_q;
    rsp0_res_d   = rsp0_valid_d ? alu : rsp0_res_q;
    rsp1_res_d   = rsp1_valid_d ? alu : rsp1_res_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q        <= 1'b0;
      s1_v_q       <= 1'b0;
      s1_id_q      <= 1'b0;
      s1_op_q      <= '0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_cin_q     <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_res_q   <= '0;
      rsp1_res_q   <= '0;
`ifdef ALU_ARB_LOCK_EN
      own_v_q      <= 1'b0;
      own_id_q     <= 1'b0;
`endif
    end else begin
      ptr_q        <= ptr_d;
      s1_v_q       <= s1_v_d;
      s1_id_q      <= s1_id_d;
      s1_op_q      <= s1_op_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_cin_q     <= s1_cin_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_res_q   <= rsp0_res_d;
      rsp1_res_q   <= rsp1_res_d;
`ifdef ALU_ARB_LOCK_EN
      own_v_q      <= own_v_d;
      own_id_q     <= own_id_d;
`endif
    end
  end
  assign req0_ready  = g0;
  assign req1_ready  = g1;
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp0_result = rsp0_res_q[W-1:0];
  assign rsp0_cout   = rsp0_res_q[W];
  assign rsp1_result = rsp1_res_q[W-1:0];
  assign rsp1_cout   = rsp1_res_q[W];
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter
module tb_alu_arbiter;
  logic        clk = 1'b0, reset = 1'b1;
  logic        req0_valid, req0_ready, req0_cin, req0_lock;
  logic        req1_valid, req1_ready, req1_cin, req1_lock;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_cout, rsp1_valid, rsp1_cout;
  logic [31:0] rsp0_result, rsp1_result;
  int          n_chk = 0, n_fail = 0;
  bit          lock_en;
  always #5 clk = ~clk;
  alu_arbiter #(.W(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin), .req0_lock(req0_lock),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin), .req1_lock(req1_lock),
    .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_cout(rsp0_cout),
    .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_cout(rsp1_cout)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drv0(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic cin, input logic lk);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_cin = cin; req0_lock = lk;
  endtask
  task automatic drv1(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic cin, input logic lk);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_cin = cin; req1_lock = lk;
  endtask
  initial begin
`ifdef ALU_ARB_LOCK_EN
    lock_en = 1'b1;
`else
    lock_en = 1'b0;
`endif
    drv0(1'b1, 3'd2, 32'h1, 32'h1, 1'b0, 1'b0);
    drv1(1'b1, 3'd0, 32'h1, 32'h1, 1'b0, 1'b0);
    repeat (3) tick();
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_rsp0_result", rsp0_result, 0);
    chk("rst_rsp1_cout", rsp1_cout, 0);
    // single op: 0xFFFFFFFF + 1 wraps with carry out
    reset = 1'b0;
    drv0(1'b1, 3'd2, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    drv1(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("t1_ready0", req0_ready, 1);
    chk("t1_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("t1_rsp0_early", rsp0_valid, 0);
    chk("t1_rsp1_c1", rsp1_valid, 0);
    tick();
    chk("t1_rsp0_valid", rsp0_valid, 1);
    chk("t1_rsp0_result", rsp0_result, 0);
    chk("t1_rsp0_cout", rsp0_cout, 1);
    chk("t1_rsp1_c2", rsp1_valid, 0);
    tick();
    chk("t1_rsp0_pulse", rsp0_valid, 0);
    chk("t1_rsp0_hold_cout", rsp0_cout, 1);
    chk("t1_rsp1_c3", rsp1_valid, 0);
    // subtract with borrow, then an invalid opcode, back to back on port 1
    drv1(1'b1, 3'd3, 32'h5, 32'h7, 1'b0, 1'b0);
    #1;
    chk("t3_ready1_sub", req1_ready, 1);
    tick();
    drv1(1'b1, 3'd7, 32'h1234, 32'h5678, 1'b1, 1'b0);
    #1;
    chk("t3_ready1_op7", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    #1;
    chk("t3_sub_valid", rsp1_valid, 1);
    chk("t3_sub_result", rsp1_result, 32'hFFFF_FFFE);
    chk("t3_sub_cout", rsp1_cout, 1);
    chk("t3_rsp0_quiet", rsp0_valid, 0);
    tick();
    chk("t3_op7_valid", rsp1_valid, 1);
    chk("t3_op7_result", rsp1_result, 0);
    chk("t3_op7_cout", rsp1_cout, 0);
    tick();
    chk("t3_rsp1_end", rsp1_valid, 0);
    // contention: pointer now at port 0, grants alternate from port 0
    drv0(1'b1, 3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1'b0);
    drv1(1'b1, 3'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 6) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      #1;
      if (i < 6) begin
        chk($sformatf("t2_ready0_%0d", i), req0_ready, (i % 2 == 0) ? 64'd1 : 64'd0);
        chk($sformatf("t2_ready1_%0d", i), req1_ready, (i % 2 == 1) ? 64'd1 : 64'd0);
      end
      if (i >= 2) begin
        chk($sformatf("t2_rsp0_valid_%0d", i), rsp0_valid, (i % 2 == 0) ? 64'd1 : 64'd0);
        chk($sformatf("t2_rsp1_valid_%0d", i), rsp1_valid, (i % 2 == 1) ? 64'd1 : 64'd0);
        if (i % 2 == 0) chk($sformatf("t2_rsp0_result_%0d", i), rsp0_result, 32'hFFF0_FFF0);
        else chk($sformatf("t2_rsp1_result_%0d", i), rsp1_result, 32'hF000_F000);
      end
      tick();
    end
    chk("t2_rsp0_end", rsp0_valid, 0);
    chk("t2_rsp1_end", rsp1_valid, 0);
    // reset mid-flight
    drv0(1'b1, 3'd2, 32'h1, 32'h2, 1'b0, 1'b0);
    #1;
    chk("t4_ready0", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("t4_rsp0_r0", rsp0_valid, 0);
    tick();
    chk("t4_rsp0_r1", rsp0_valid, 0);
    chk("t4_rsp1_r1", rsp1_valid, 0);
    chk("t4_rsp0_result", rsp0_result, 0);
    chk("t4_rsp1_result", rsp1_result, 0);
    chk("t4_rsp0_cout", rsp0_cout, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("t4_rsp0_after", rsp0_valid, 0);
    chk("t4_rsp1_after", rsp1_valid, 0);
    tick();
    chk("t4_rsp0_after2", rsp0_valid, 0);
    chk("t4_rsp0_result_after", rsp0_result, 0);
    // lock: port 0 locks, idles 2 cycles, then unlocks; port 1 always valid
    drv0(1'b1, 3'd2, 32'h3, 32'h4, 1'b1, 1'b1);
    drv1(1'b1, 3'd0, 32'h9, 32'h0, 1'b0, 1'b0);
    #1;
    chk("t5_ready0_lock", req0_ready, 1);
    chk("t5_ready1_lock", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("t5_ready1_idle1", req1_ready, lock_en ? 64'd0 : 64'd1);
    tick();
    #1;
    chk("t5_ready1_idle2", req1_ready, lock_en ? 64'd0 : 64'd1);
    chk("t5_rsp0_valid", rsp0_valid, 1);
    chk("t5_rsp0_result", rsp0_result, 8);
    chk("t5_rsp1_quiet", rsp1_valid, 0);
    tick();
    drv0(1'b1, 3'd2, 32'h1, 32'h1, 1'b0, 1'b0);
    #1;
    chk("t5_ready0_unlock", req0_ready, 1);
    chk("t5_ready1_unlock", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("t5_ready1_after", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
